// File: rtl/jt10_adpcma_pkg.sv
// rtl/jt10_adpcma_pkg.sv - shared constants and state type for the ADPCM-A register sequencer
package jt10_adpcma_pkg;

    localparam int NCH = 6;

    localparam logic [7:0] REG_KEY   = 8'h00;
    localparam logic [7:0] REG_ST_LO = 8'h10;
    localparam logic [7:0] REG_ST_HI = 8'h18;
    localparam logic [7:0] REG_EN_LO = 8'h20;
    localparam logic [7:0] REG_EN_HI = 8'h28;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } seq_state_e;

endpackage

// File: rtl/jt10_adpcma_prio.sv
// rtl/jt10_adpcma_prio.sv - picks the lowest pending address item, start before end
module jt10_adpcma_prio #(
    parameter int NCH = 6
) (
    input  logic [2*NCH-1:0] i_pend,
    output logic [2:0]       o_ch,
    output logic             o_is_end,
    output logic             o_valid
);

    // Bit 2n is channel n start, bit 2n+1 is channel n end; scanning downward leaves the lowest set bit.
    always_comb begin
        o_ch     = '0;
        o_is_end = 1'b0;
        o_valid  = 1'b0;
        for (int i = 2*NCH-1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_ch     = 3'(i / 2);
                o_is_end = ((i % 2) == 1);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt10_adpcma_seq.sv
// rtl/jt10_adpcma_seq.sv - ADPCM-A key/address write sequencer; JT10_ADPCMA_FLAGCLR_EN builds the flag-clear register
module jt10_adpcma_seq #(
    parameter int NCH = jt10_adpcma_pkg::NCH
) (
    input  logic            i_rst_n,
    input  logic            i_clk,
    input  logic            i_cen,
    input  logic [NCH-1:0]  i_cur_ch,
    input  logic [7:0]      i_din,
    input  logic [7:0]      i_addr,
    input  logic            i_we,
    input  logic            i_flag_we,
    input  logic [5:0]      i_flag_din,
    output logic            o_aon,
    output logic            o_aoff,
    output logic [16:0]     o_addr_in,
    output logic [2:0]      o_addr_ch,
    output logic            o_up_start,
    output logic            o_up_end,
    output logic [5:0]      o_clr_flags,
    output logic            o_busy
);
    import jt10_adpcma_pkg::*;

    logic [7:0]     r_st_lo [NCH];
    logic [7:0]     r_st_hi [NCH];
    logic [7:0]     r_en_lo [NCH];
    logic [7:0]     r_en_hi [NCH];
    logic [NCH-1:0] r_kon_pend, r_koff_pend, r_st_pend, r_en_pend;
    seq_state_e     r_state;
    logic [2:0]     r_addr_ch;
    logic           r_is_end;
    logic [16:0]    r_addr_in;
    logic           r_up_start, r_up_end;

    logic [7:0]     w_st_lo_nxt [NCH];
    logic [7:0]     w_st_hi_nxt [NCH];
    logic [7:0]     w_en_lo_nxt [NCH];
    logic [7:0]     w_en_hi_nxt [NCH];
    logic [NCH-1:0] w_st_set, w_en_set, w_st_clr, w_en_clr;
    logic [NCH-1:0] w_kon_set, w_koff_set, w_kon_clr, w_koff_clr, w_blk, w_ch_1h;
    logic [2*NCH-1:0] w_pend;
    logic           w_key_we, w_hit;
    logic [2:0]     w_prio_ch;
    logic           w_prio_is_end, w_prio_valid;
    logic [16:0]    w_load_val, w_hold_val;

    always_comb begin
        w_st_set = '0;
        w_en_set = '0;
        w_pend   = '0;
        for (int n = 0; n < NCH; n++) begin
            w_st_set[n]    = i_we && (i_addr == REG_ST_HI + 8'(n));
            w_en_set[n]    = i_we && (i_addr == REG_EN_HI + 8'(n));
            w_st_lo_nxt[n] = (i_we && (i_addr == REG_ST_LO + 8'(n))) ? i_din : r_st_lo[n];
            w_en_lo_nxt[n] = (i_we && (i_addr == REG_EN_LO + 8'(n))) ? i_din : r_en_lo[n];
            w_st_hi_nxt[n] = w_st_set[n] ? i_din : r_st_hi[n];
            w_en_hi_nxt[n] = w_en_set[n] ? i_din : r_en_hi[n];
            w_pend[2*n]    = r_st_pend[n];
            w_pend[2*n+1]  = r_en_pend[n];
        end
    end

    jt10_adpcma_prio #(.NCH(NCH)) u_prio (
        .i_pend   (w_pend),
        .o_ch     (w_prio_ch),
        .o_is_end (w_prio_is_end),
        .o_valid  (w_prio_valid)
    );

    always_comb begin
        w_key_we   = i_we && (i_addr == REG_KEY);
        w_kon_set  = (w_key_we && !i_din[7]) ? i_din[NCH-1:0] : '0;
        w_koff_set = (w_key_we &&  i_din[7]) ? i_din[NCH-1:0] : '0;
        w_blk      = r_st_pend | r_en_pend;
        // A key-off slot also consumes any key-on; a blocked key-on stays pending.
        w_koff_clr = i_cen ? i_cur_ch : '0;
        w_kon_clr  = i_cen ? (i_cur_ch & (r_koff_pend | ~w_blk)) : '0;
        w_hit      = (r_state == ST_ISSUE) && i_cen && i_cur_ch[r_addr_ch];
        w_ch_1h    = NCH'(1) << r_addr_ch;
        w_st_clr   = (w_hit && !r_is_end) ? w_ch_1h : '0;
        w_en_clr   = (w_hit &&  r_is_end) ? w_ch_1h : '0;
        // Values come from next-state shadows so a same-cycle rewrite is never lost.
        w_load_val = w_prio_is_end ? {1'b0, w_en_hi_nxt[w_prio_ch], w_en_lo_nxt[w_prio_ch]}
                                   : {1'b0, w_st_hi_nxt[w_prio_ch], w_st_lo_nxt[w_prio_ch]};
        w_hold_val = r_is_end ? {1'b0, w_en_hi_nxt[r_addr_ch], w_en_lo_nxt[r_addr_ch]}
                              : {1'b0, w_st_hi_nxt[r_addr_ch], w_st_lo_nxt[r_addr_ch]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NCH; n++) begin
                r_st_lo[n] <= '0;
                r_st_hi[n] <= '0;
                r_en_lo[n] <= '0;
                r_en_hi[n] <= '0;
            end
            r_kon_pend  <= '0;
            r_koff_pend <= '0;
            r_st_pend   <= '0;
            r_en_pend   <= '0;
            r_state     <= ST_IDLE;
            r_addr_ch   <= '0;
            r_is_end    <= 1'b0;
            r_addr_in   <= '0;
            r_up_start  <= 1'b0;
            r_up_end    <= 1'b0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                r_st_lo[n] <= w_st_lo_nxt[n];
                r_st_hi[n] <= w_st_hi_nxt[n];
                r_en_lo[n] <= w_en_lo_nxt[n];
                r_en_hi[n] <= w_en_hi_nxt[n];
            end
            r_kon_pend  <= (r_kon_pend  & ~w_kon_clr)  | w_kon_set;
            r_koff_pend <= (r_koff_pend & ~w_koff_clr) | w_koff_set;
            r_st_pend   <= (r_st_pend   & ~w_st_clr)   | w_st_set;
            r_en_pend   <= (r_en_pend   & ~w_en_clr)   | w_en_set;
            case (r_state)
                ST_IDLE: begin
                    if (w_prio_valid) begin
                        r_addr_ch  <= w_prio_ch;
                        r_is_end   <= w_prio_is_end;
                        r_addr_in  <= w_load_val;
                        r_up_start <= !w_prio_is_end;
                        r_up_end   <= w_prio_is_end;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_addr_in <= w_hold_val;
                    if (w_hit) begin
                        r_up_start <= 1'b0;
                        r_up_end   <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef JT10_ADPCMA_FLAGCLR_EN
    logic [5:0] r_clr_flags;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_flags <= '0;
        end else begin
            r_clr_flags <= i_flag_we ? i_flag_din : 6'd0;
        end
    end

    assign o_clr_flags = r_clr_flags;
`else
    logic w_unused_flag;
    assign w_unused_flag = &{1'b0, i_flag_we, i_flag_din};
    assign o_clr_flags   = '0;
`endif

    assign o_aon      = |(r_kon_pend & i_cur_ch & ~w_blk & ~r_koff_pend);
    assign o_aoff     = |(r_koff_pend & i_cur_ch);
    assign o_addr_in  = r_addr_in;
    assign o_addr_ch  = r_addr_ch;
    assign o_up_start = r_up_start;
    assign o_up_end   = r_up_end;
    assign o_busy     = |{r_kon_pend, r_koff_pend, r_st_pend, r_en_pend};

endmodule
